mpu_sched: RTL and testbench
============================

Name: mpu_sched

Overview:
- Top-level sequencer for the MPU6050 mid layer (mpu_mid); sits between the flight-control core and mpu_mid.
- After reset it waits for sensor power-up, pulses one init, then issues periodic read bursts at a fixed sample rate.
- Collects the 7 returned 16-bit words (ax, ay, az, temp, gx, gy, gz) into a coherent shadow frame and presents it with a one-cycle valid strobe.
- Counts overruns and reports status.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- SAMPLE_HZ, 1000, read-burst rate; SAMPLE_DIV = CLK_HZ/SAMPLE_HZ.
- PWRUP_CYC, 10000000, cycles to wait after reset before init (100 ms).
- TMO_CYC, 2000000, watchdog limit per init/read transaction (watchdog build only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  when low, no new read bursts start; an in-flight burst completes.
- init_start  out  1  one-cycle pulse to mpu_mid.
- read_start  out  1  one-cycle pulse to mpu_mid.
- mid_done  in  1  one-cycle pulse from mpu_mid at end of an init or read transaction.
- mid_word_vld  in  1  data_packed/word index valid this cycle.
- mid_idx  in  3  word index 0..6.
- mid_word  in  16  data_packed from mpu_mid.
- frame  out  112  {gz,gy,gx,temp,az,ay,ax}; ax in bits [15:0].
- frame_vld  out  1  one-cycle strobe; frame is stable until the next strobe.
- ready  out  1  high once init has completed.
- overrun_cnt  out  8  saturating count of sample ticks missed while busy.
- err  out  1  sticky; set by a watchdog timeout (watchdog build) or an incomplete frame.

Behaviour:
- Reset values: all outputs 0; state PWRUP; counters 0.
- Sample tick: free-running divider counting 0..SAMPLE_DIV-1; tick asserts when the count wraps.
  - The divider runs from reset, independent of state.
- States:
  - PWRUP: count PWRUP_CYC cycles, then go to INIT.
  - INIT: assert init_start for exactly 1 cycle, then go to INIT_WAIT.
  - INIT_WAIT: on mid_done, set ready=1 and go to IDLE.
  - IDLE: on tick with enable=1, go to RD.
  - RD: assert read_start for 1 cycle, clear the word mask, go to RD_WAIT.
  - RD_WAIT: on mid_word_vld, write mid_word into shadow slot mid_idx and set mask bit mid_idx. On mid_done, go to IDLE.
    - If mask==7'h7F: copy shadow to frame and pulse frame_vld on the next cycle (latency 1 clk after mid_done).
    - Otherwise: set err and leave frame and frame_vld untouched.
- Word index handling:
  - mid_idx 7 is ignored.
  - A repeated index overwrites its slot.
- Tick while not in IDLE (PWRUP/INIT states excluded): overrun_cnt increments, saturating at 255; the tick is dropped, not queued.
- Simultaneous tick and mid_done in RD_WAIT: counts as an overrun; the frame completes normally.
- mid_word_vld and mid_done in the same cycle: the word is captured before the mask check.
- enable low in IDLE: ticks are ignored and do not count as overruns.
- rst mid-burst: everything returns to PWRUP, and init is reissued after PWRUP_CYC.
  - frame_vld must not pulse with partial data.
- read_start and init_start are never high simultaneously and never high for two consecutive cycles.

Optional Feature:
- Macro MPU_SCHED_WDOG_EN.
- Defined:
  - A watchdog counts cycles in INIT_WAIT and RD_WAIT.
  - Reaching TMO_CYC sets err, clears ready and goes to INIT (re-init of the sensor).
  - The counter clears on every state entry.
- Undefined: no watchdog logic; the WAIT states wait indefinitely and err is set only by an incomplete frame.

Decomposition:
- Package mpu_pkg holds:
  - state enum (PWRUP, INIT, INIT_WAIT, IDLE, RD, RD_WAIT);
  - NUM_WORDS=7;
  - word index constants IDX_AX..IDX_GZ;
  - FRAME_W=112.
- One natural sub-module: mpu_tick_gen (sample divider with wrap pulse), parameterised by DIV.

Test Plan:
- Reset, then hold with a behavioural mpu_mid model returning mid_done 50 cycles after init_start -> init_start pulses once at cycle PWRUP_CYC+1; ready=1 after mid_done. Run with PWRUP_CYC=100, SAMPLE_DIV=500.
- Read burst where the model returns words 0..6 = 16'h1000+i, then mid_done -> frame_vld pulses once, 1 cycle after mid_done. frame[15:0]=16'h1000, frame[111:96]=16'h1006.
- Model delays mid_done by 600 cycles (longer than SAMPLE_DIV) -> overrun_cnt=1; no extra read_start issued during the burst.
- Model omits index 4 -> err=1, frame_vld stays low, previous frame retained; the next good burst updates frame.
- Assert rst midway through RD_WAIT -> all outputs 0 the next cycle; init is reissued after PWRUP_CYC; no frame_vld pulse.
- With MPU_SCHED_WDOG_EN and TMO_CYC=300, model never sends mid_done -> err=1 and ready=0 at timeout, followed by a new init_start pulse.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared types and constants for the MPU6050 sample scheduler.
// Holds the sequencer state encoding, frame geometry and word slot indices.
// Imported by mpu_sched and its sub-modules.
package mpu_pkg;

    typedef enum logic [2:0] {
        PWRUP     = 3'd0,
        INIT      = 3'd1,
        INIT_WAIT = 3'd2,
        IDLE      = 3'd3,
        RD        = 3'd4,
        RD_WAIT   = 3'd5
    } state_e;

    localparam int NUM_WORDS = 7;
    localparam int WORD_W    = 16;
    localparam int FRAME_W   = NUM_WORDS * WORD_W;   // 112

    // Slot order inside the frame, ax in the least significant word.
    localparam logic [2:0] IDX_AX   = 3'd0;
    localparam logic [2:0] IDX_AY   = 3'd1;
    localparam logic [2:0] IDX_AZ   = 3'd2;
    localparam logic [2:0] IDX_TEMP = 3'd3;
    localparam logic [2:0] IDX_GX   = 3'd4;
    localparam logic [2:0] IDX_GY   = 3'd5;
    localparam logic [2:0] IDX_GZ   = 3'd6;

    // Index 7 does not name a slot and is dropped on capture.
    function automatic logic idx_ok(input logic [2:0] idx);
        return idx <= IDX_GZ;
    endfunction

endpackage

// File: rtl/mpu_tick_gen.sv
// Free-running sample divider: counts 0..DIV-1 and flags the wrap cycle.
// Ports: clk, rst (sync, active-high) in; tick_o out, high for the one cycle the count is DIV-1.
// Latency: tick_o is a decode of the registered count; no backpressure, never stalls.
module mpu_tick_gen #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/mpu_sched.sv
// Top-level sequencer for mpu_mid: power-up wait, one init, then periodic read bursts
// assembled into a 7-word frame. frame_vld follows the burst-ending mid_done by 1 clk.
// No backpressure: ticks arriving while a burst is in flight are dropped and counted.
// Ports: clk/rst (sync active-high); enable gates new bursts; init_start/read_start pulse
// mpu_mid; mid_done/mid_word_vld/mid_idx/mid_word return data; frame/frame_vld, ready,
// overrun_cnt, err report status. Optional watchdog: define MPU_SCHED_WDOG_EN (adds TMO_CYC).
module mpu_sched
    import mpu_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned SAMPLE_HZ = 1000,
    parameter int unsigned PWRUP_CYC = 10000000
`ifdef MPU_SCHED_WDOG_EN
    ,
    parameter int unsigned TMO_CYC   = 2000000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic                init_start,
    output logic                read_start,
    input  logic                mid_done,
    input  logic                mid_word_vld,
    input  logic [2:0]          mid_idx,
    input  logic [15:0]         mid_word,
    output logic [FRAME_W-1:0]  frame,
    output logic                frame_vld,
    output logic                ready,
    output logic [7:0]          overrun_cnt,
    output logic                err
);

    localparam int unsigned SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;

    logic tick;

    mpu_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    state_e                 state_q;
    logic [31:0]            pwr_cnt_q;
    logic [NUM_WORDS-1:0]   mask_q, mask_d;
    logic [FRAME_W-1:0]     shadow_q, shadow_d;
    logic [FRAME_W-1:0]     frame_q;
    logic                   init_start_q, read_start_q, frame_vld_q, ready_q, err_q;
    logic [7:0]             overrun_q;
    logic                   busy_tick;

    // Merge this cycle's word into the shadow so a word arriving together with
    // mid_done still takes part in the completeness check and the frame copy.
    always_comb begin
        shadow_d = shadow_q;
        mask_d   = mask_q;
        if (state_q == RD_WAIT && mid_word_vld && idx_ok(mid_idx)) begin
            shadow_d[{mid_idx, 4'b0000} +: WORD_W] = mid_word;
            mask_d[mid_idx]                        = 1'b1;
        end
    end

    // Only a burst in flight makes a tick an overrun; power-up and init are not sampling yet.
    assign busy_tick = tick && (state_q == RD || state_q == RD_WAIT);

`ifdef MPU_SCHED_WDOG_EN
    logic [31:0] wdog_q;
    logic        in_wait;
    assign in_wait = (state_q == INIT_WAIT || state_q == RD_WAIT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PWRUP;
            pwr_cnt_q    <= '0;
            mask_q       <= '0;
            shadow_q     <= '0;
            frame_q      <= '0;
            init_start_q <= 1'b0;
            read_start_q <= 1'b0;
            frame_vld_q  <= 1'b0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            overrun_q    <= '0;
`ifdef MPU_SCHED_WDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            init_start_q <= 1'b0;
            read_start_q <= 1'b0;
            frame_vld_q  <= 1'b0;

            if (busy_tick && overrun_q != 8'hFF) begin
                overrun_q <= overrun_q + 8'd1;
            end

            // Start pulses are raised on the transition so they are high exactly
            // during the one-cycle INIT / RD states.
            case (state_q)
                PWRUP: begin
                    if (pwr_cnt_q == 32'(PWRUP_CYC - 1)) begin
                        pwr_cnt_q    <= '0;
                        state_q      <= INIT;
                        init_start_q <= 1'b1;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + 32'd1;
                    end
                end
                INIT: state_q <= INIT_WAIT;
                INIT_WAIT: begin
                    if (mid_done) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (tick && enable) begin
                        state_q      <= RD;
                        read_start_q <= 1'b1;
                    end
                end
                RD: begin
                    mask_q  <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    shadow_q <= shadow_d;
                    mask_q   <= mask_d;
                    if (mid_done) begin
                        state_q <= IDLE;
                        if (&mask_d) begin
                            frame_q     <= shadow_d;
                            frame_vld_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= PWRUP;
            endcase

`ifdef MPU_SCHED_WDOG_EN
            // Never wait-to-wait transitions, so clearing outside the wait
            // states restarts the count on every entry.
            if (in_wait) begin
                wdog_q <= wdog_q + 32'd1;
            end else begin
                wdog_q <= '0;
            end
            if (in_wait && !mid_done && wdog_q == 32'(TMO_CYC - 1)) begin
                err_q        <= 1'b1;
                ready_q      <= 1'b0;
                state_q      <= INIT;
                init_start_q <= 1'b1;
            end
`endif
        end
    end

    assign init_start  = init_start_q;
    assign read_start  = read_start_q;
    assign frame       = frame_q;
    assign frame_vld   = frame_vld_q;
    assign ready       = ready_q;
    assign overrun_cnt = overrun_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mpu_sched.sv
// Self-checking bench for mpu_sched with a behavioural mpu_mid driver.
// Directed burst table plus randomized bursts checked against a frame/overrun model.
// Ends with reset-in-burst and stalled-transaction scenarios.
module tb_mpu_sched;

    localparam int CLK_HZ    = 500000;
    localparam int SAMPLE_HZ = 1000;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;   // 500
    localparam int PWRUP     = 100;
    localparam int TMO       = 300;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b1;
    logic         mid_done = 1'b0;
    logic         mid_word_vld = 1'b0;
    logic [2:0]   mid_idx = 3'd0;
    logic [15:0]  mid_word = 16'd0;
    logic         init_start, read_start, frame_vld, ready, err;
    logic [111:0] frame;
    logic [7:0]   overrun_cnt;

    always #5 clk = ~clk;

    mpu_sched #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .PWRUP_CYC (PWRUP)
`ifdef MPU_SCHED_WDOG_EN
        ,
        .TMO_CYC   (TMO)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .init_start   (init_start),
        .read_start   (read_start),
        .mid_done     (mid_done),
        .mid_word_vld (mid_word_vld),
        .mid_idx      (mid_idx),
        .mid_word     (mid_word),
        .frame        (frame),
        .frame_vld    (frame_vld),
        .ready        (ready),
        .overrun_cnt  (overrun_cnt),
        .err          (err)
    );

    // Cycle number since reset: 1 in the first cycle after the last reset edge.
    int gcyc;
    always @(posedge clk) begin
        if (rst) gcyc <= 1;
        else     gcyc <= gcyc + 1;
    end

    // Pulse-protocol monitor.
    int   viol_mon = 0, cnt_init = 0, cnt_fv = 0;
    logic prev_is = 1'b0, prev_rs = 1'b0, prev_fv = 1'b0;
    always @(negedge clk) begin
        if (init_start && read_start) viol_mon++;
        if (init_start && prev_is)    viol_mon++;
        if (read_start && prev_rs)    viol_mon++;
        if (frame_vld && prev_fv)     viol_mon++;
        if (init_start) cnt_init++;
        if (frame_vld)  cnt_fv++;
        prev_is = init_start;
        prev_rs = read_start;
        prev_fv = frame_vld;
    end

    int n_chk = 0, n_fail = 0, viol = 0, exp_init = 0, exp_fv = 0;

    // Reference model state.
    logic [111:0] frame_m = '0;
    logic         err_m = 1'b0;
    int           ovr_m = 0;

    // Word list for the current burst, sent one per cycle from r+1.
    logic [2:0]  l_idx[16];
    logic [15:0] l_val[16];
    int          l_len;

    typedef struct {
        logic [6:0]  send;
        logic [15:0] base;
        int          dur;      // cycles from read_start to mid_done
        bit          pause;    // hold enable low over the first idle tick
        logic        exp_vld;
        logic        exp_err;
        logic [7:0]  exp_ovr;
    } row_t;
    row_t tbl[5];

    task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mid();
        mid_done     = 1'b0;
        mid_word_vld = 1'b0;
        mid_idx      = 3'd0;
        mid_word     = 16'd0;
    endtask

    function automatic int next_tick(input int c);
        return ((c + DIV - 1) / DIV) * DIV;
    endfunction

    function automatic int ticks_in(input int a, input int b);
        return b / DIV - (a - 1) / DIV;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_init_start"}, init_start, 0);
        chk({tag, "_read_start"}, read_start, 0);
        chk({tag, "_frame"}, frame, 0);
        chk({tag, "_frame_vld"}, frame_vld, 0);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_overrun"}, overrun_cnt, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Waits for init_start, answers with mid_done 50 cycles later.
    task automatic do_init();
        int n = 0;
        while (!init_start && n < 1000) begin step(); n++; end
        chk("init_cycle", gcyc, PWRUP + 1);
        chk("ready_before_init_done", ready, 0);
        exp_init++;
        repeat (50) step();
        mid_done = 1'b1;
        step();
        mid_done = 1'b0;
        chk("ready_after_init_done", ready, 1);
    endtask

    task automatic next_burst(input bit pause, input int idle_start, output int r);
        int t0, exp_r, n;
        n = 0;
        if (pause) begin
            t0 = next_tick(idle_start);
            enable = 1'b0;
            while (gcyc < t0 + 1 && n < 5000) begin
                step(); n++;
                if (read_start) viol++;
            end
            enable = 1'b1;
            exp_r = next_tick(t0 + 1) + 1;
        end else begin
            exp_r = next_tick(idle_start) + 1;
        end
        n = 0;
        while (!read_start && n < 2000) begin step(); n++; end
        chk("read_start_cycle", gcyc, exp_r);
        r = gcyc;
    endtask

    // Plays the word list, then mid_done at cycle r+dur; checks at r+dur+1.
    task automatic run_burst(input int r, input int dur);
        logic [111:0] f;
        logic [6:0]   pres;
        f    = '0;
        pres = '0;
        for (int c = 1; c <= dur; c++) begin
            step();
            clr_mid();
            if (read_start) viol++;
            if (frame_vld)  viol++;
            if (c <= l_len) begin
                mid_word_vld = 1'b1;
                mid_idx      = l_idx[c-1];
                mid_word     = l_val[c-1];
            end
            if (c == dur) mid_done = 1'b1;
        end
        step();
        clr_mid();
        for (int k = 0; k < l_len; k++) begin
            if (l_idx[k] != 3'd7) begin
                f[l_idx[k]*16 +: 16] = l_val[k];
                pres[l_idx[k]]       = 1'b1;
            end
        end
        if (pres == 7'h7F) begin
            frame_m = f;
            exp_fv++;
        end else begin
            err_m = 1'b1;
        end
        ovr_m = ovr_m + ticks_in(r, r + dur);
        if (ovr_m > 255) ovr_m = 255;
        chk("frame_vld", frame_vld, (pres == 7'h7F));
        chk("err", err, err_m);
        chk("overrun_cnt", overrun_cnt, ovr_m);
        chk("frame", frame, frame_m);
    endtask

    initial begin
        int r, idle, dur, nids, j, tmp, ne, i1, n;
        int ids[7];
        logic [6:0] msk;

        tbl[0] = '{7'h7F, 16'h1000, 20,  1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{7'h7F, 16'h2000, 600, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[2] = '{7'h6F, 16'h3000, 20,  1'b0, 1'b0, 1'b1, 8'd1};
        tbl[3] = '{7'h7F, 16'h4000, 7,   1'b0, 1'b1, 1'b1, 8'd1};
        tbl[4] = '{7'h7F, 16'h5000, 499, 1'b1, 1'b1, 1'b1, 8'd2};

        // Reset state.
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        do_init();
        idle = gcyc;

        // Directed bursts.
        for (int i = 0; i < 5; i++) begin
            l_len = 0;
            for (int k = 0; k < 7; k++) begin
                if (tbl[i].send[k]) begin
                    l_idx[l_len] = 3'(k);
                    l_val[l_len] = tbl[i].base + 16'(k);
                    l_len++;
                end
            end
            next_burst(tbl[i].pause, idle, r);
            run_burst(r, tbl[i].dur);
            chk("tbl_frame_vld", frame_vld, tbl[i].exp_vld);
            chk("tbl_err", err, tbl[i].exp_err);
            chk("tbl_overrun", overrun_cnt, tbl[i].exp_ovr);
            if (i == 0) begin
                chk("frame_ax", frame[15:0], 16'h1000);
                chk("frame_gz", frame[111:96], 16'h1006);
            end
            idle = r + tbl[i].dur + 1;
        end

        // Randomized bursts: shuffled order, omissions, repeats, index 7, long bursts.
        for (int b = 0; b < 10; b++) begin
            msk  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h7F;
            nids = 0;
            for (int k = 0; k < 7; k++) if (msk[k]) begin ids[nids] = k; nids++; end
            for (int k = nids - 1; k > 0; k--) begin
                j = $urandom_range(0, k);
                tmp = ids[k]; ids[k] = ids[j]; ids[j] = tmp;
            end
            l_len = 0;
            for (int k = 0; k < nids; k++) begin
                l_idx[l_len] = 3'(ids[k]);
                l_val[l_len] = 16'($urandom);
                l_len++;
            end
            ne = $urandom_range(0, 2);
            for (int e = 0; e < ne; e++) begin
                l_idx[l_len] = 3'($urandom_range(0, 7));
                l_val[l_len] = 16'($urandom);
                l_len++;
            end
            if (l_len == 0) begin
                l_idx[0] = 3'd7; l_val[0] = 16'hDEAD; l_len = 1;
            end
            dur = ($urandom_range(0, 2) == 0) ? l_len : l_len + $urandom_range(1, 700);
            next_burst(1'b0, idle, r);
            run_burst(r, dur);
            idle = r + dur + 1;
        end

        // Reset in the middle of RD_WAIT.
        next_burst(1'b0, idle, r);
        step(); mid_word_vld = 1'b1; mid_idx = 3'd0; mid_word = 16'hAAAA;
        step(); mid_idx = 3'd1; mid_word = 16'hBBBB; rst = 1'b1;
        step(); rst = 1'b0; clr_mid();
        check_all_zero("rst_mid_burst");
        frame_m = '0; err_m = 1'b0; ovr_m = 0;
        do_init();
        idle = gcyc;

        // Transaction that never ends.
        next_burst(1'b0, idle, r);
`ifdef MPU_SCHED_WDOG_EN
        n = 0;
        while (!err && n < TMO + 50) begin step(); n++; end
        chk("wdog_err_cycle", gcyc, r + TMO + 1);
        chk("wdog_ready", ready, 0);
        chk("wdog_init_start", init_start, 1);
        exp_init++;
        i1 = gcyc;
        step();
        n = 0;
        while (!init_start && n < TMO + 50) begin step(); n++; end
        chk("wdog_reinit_cycle", gcyc, i1 + TMO + 1);
        chk("wdog_err_sticky", err, 1);
        exp_init++;
`else
        i1 = 0; n = 0;
        repeat (1200) step();
        chk("stall_err", err, 0);
        chk("stall_ready", ready, 1);
        chk("stall_overrun", overrun_cnt, ticks_in(r, gcyc - 1));
`endif

        repeat (2) step();
        chk("init_pulses", cnt_init, exp_init);
        chk("frame_vld_pulses", cnt_fv, exp_fv);
        chk("burst_violations", viol, 0);
        chk("pulse_protocol", viol_mon, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
